// File: rtl/uart_fifo_pkg.sv
// UART peripheral shared definitions: register indices, STATUS/CTRL bit
// positions and the 2-bit TX/RX state encodings.
package uart_fifo_pkg;

  // Register indices on the 4-bit address bus
  localparam logic [3:0] REG_DATA   = 4'd0;
  localparam logic [3:0] REG_STATUS = 4'd1;
  localparam logic [3:0] REG_CTRL   = 4'd2;
  localparam logic [3:0] REG_DIV    = 4'd3;

  // STATUS bit positions
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_AVAIL   = 2;
  localparam int ST_RX_FULL    = 3;
  localparam int ST_RX_OVERRUN = 4;
  localparam int ST_FRAME_ERR  = 5;
  localparam int ST_TX_BUSY    = 6;

  // CTRL bit positions
  localparam int CTRL_TX_EN     = 0;
  localparam int CTRL_RX_EN     = 1;
  localparam int CTRL_IRQ_RX_EN = 2;
  localparam int CTRL_IRQ_TX_EN = 3;
  localparam int CTRL_LOOPBACK  = 4;

  // TX FSM encodings
  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  // RX FSM encodings
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_fifo_periph_if.sv
// CPU-side register bus of the UART peripheral. The CPU drives the
// master modport; the peripheral implements the slave modport.
interface uart_fifo_periph_if #(
  parameter int WIDTH = 32
);
  logic             cs;
  logic             wen;
  logic             ren;
  logic [3:0]       addr;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;

  modport master (output cs, output wen, output ren, output addr, output din, input dout);
  modport slave  (input cs, input wen, input ren, input addr, input din, output dout);
endinterface

// File: rtl/uart_sync_fifo.sv
// Small synchronous FIFO with the head visible on dout without latency.
// A push and a pop in the same cycle are both taken, even when full, and
// when empty the pushed word is passed straight through to dout.
module uart_sync_fifo #(
  parameter int DW    = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DW-1:0]            din,
  output logic [DW-1:0]            dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW:0]   count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign empty   = (count_reg == '0);
  assign count   = count_reg;
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & (~empty | push);
  assign dout    = empty ? din : mem[rd_ptr_reg];

  // Storage array; no reset so it maps onto distributed RAM
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_reg] <= din;
  end

  // Pointers wrap naturally at the power-of-two depth; count tracks occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop_ok)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push_ok && !pop_ok)      count_reg <= count_reg + 1'b1;
      else if (pop_ok && !push_ok) count_reg <= count_reg - 1'b1;
    end
  end
endmodule

// File: rtl/uart_fifo_periph.sv
// Memory-mapped 8N1 UART with TX/RX FIFOs, STATUS/CTRL/DIV registers and
// a registered level interrupt. Optional feature macro: UART_LOOPBACK_EN
// (internal TxD->RX loopback selected by CTRL bit 4).
module uart_fifo_periph
  import uart_fifo_pkg::*;
#(
  parameter int          WIDTH      = 32,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] DIV_RESET  = 16'd433
) (
  input  logic              clk,
  input  logic              resetn,
  uart_fifo_periph_if.slave bus,
  input  logic              RxD,
  output logic              TxD,
  output logic              irq
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Registers
  logic [4:0]  ctrl_reg;
  logic [15:0] div_reg;
  logic        overrun_reg;
  logic        frame_err_reg;
  logic        irq_reg;

  // Bus decode
  logic wr_en;
  logic rd_en;
  logic tx_push;
  logic rx_pop;
  logic status_wr;

  // FIFO interfaces
  logic [7:0]    tx_head;
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  logic          tx_pop;
  logic [7:0]    rx_head;
  logic          rx_full;
  logic          rx_empty;
  logic [CW-1:0] rx_count;
  logic          rx_push;
  logic          rx_avail;

  // TX engine
  logic [1:0]  tx_state_reg;
  logic [15:0] tx_cnt_reg;
  logic [2:0]  tx_bit_reg;
  logic [7:0]  tx_shift_reg;
  logic        txd_reg;
  logic        tx_busy;

  // RX engine
  logic        rx_src;
  logic        sync1_reg;
  logic        sync2_reg;
  logic [1:0]  rx_state_reg;
  logic [15:0] rx_cnt_reg;
  logic [2:0]  rx_bit_reg;
  logic [7:0]  rx_shift_reg;
  logic        rx_stop_sample;
  logic        frame_bad;

  logic [6:0]       status;
  logic [WIDTH-1:0] rdata;

  assign wr_en     = bus.cs & bus.wen;
  assign rd_en     = bus.cs & bus.ren;
  assign tx_push   = wr_en & (bus.addr == REG_DATA);
  assign status_wr = wr_en & (bus.addr == REG_STATUS);
  assign rx_avail  = ~rx_empty;
  assign rx_pop    = rd_en & (bus.addr == REG_DATA) & rx_avail;
  assign tx_busy   = (tx_state_reg != TX_IDLE);
  assign tx_pop    = (tx_state_reg == TX_IDLE) & ctrl_reg[CTRL_TX_EN] & ~tx_empty;

  // A completed frame is judged on the stop-bit sample
  assign rx_stop_sample = (rx_state_reg == RX_STOP) && (rx_cnt_reg == '0);
  assign rx_push        = rx_stop_sample & sync2_reg;
  assign frame_bad      = rx_stop_sample & ~sync2_reg;

`ifdef UART_LOOPBACK_EN
  assign rx_src = ctrl_reg[CTRL_LOOPBACK] ? txd_reg : RxD;
  assign TxD    = ctrl_reg[CTRL_LOOPBACK] ? 1'b1 : txd_reg;
`else
  assign rx_src = RxD;
  assign TxD    = txd_reg;
`endif

  assign irq = irq_reg;

  uart_sync_fifo #(.DW(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk(clk), .resetn(resetn), .push(tx_push), .pop(tx_pop),
    .din(bus.din[7:0]), .dout(tx_head), .full(tx_full), .empty(tx_empty),
    .count(tx_count)
  );

  uart_sync_fifo #(.DW(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk(clk), .resetn(resetn), .push(rx_push), .pop(rx_pop),
    .din(rx_shift_reg), .dout(rx_head), .full(rx_full), .empty(rx_empty),
    .count(rx_count)
  );

  // CTRL and DIV registers; loopback bit only exists when the feature is built
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ctrl_reg <= '0;
      div_reg  <= DIV_RESET;
    end else if (wr_en) begin
`ifdef UART_LOOPBACK_EN
      if (bus.addr == REG_CTRL) ctrl_reg <= bus.din[4:0];
`else
      if (bus.addr == REG_CTRL) ctrl_reg <= {1'b0, bus.din[3:0]};
`endif
      if (bus.addr == REG_DIV)  div_reg  <= bus.din[15:0];
    end
  end

  // Sticky error flags: a new event wins over a same-cycle W1C
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      overrun_reg   <= 1'b0;
      frame_err_reg <= 1'b0;
    end else begin
      if (rx_push && rx_full && !rx_pop)                overrun_reg <= 1'b1;
      else if (status_wr && bus.din[ST_RX_OVERRUN])     overrun_reg <= 1'b0;
      if (frame_bad)                                    frame_err_reg <= 1'b1;
      else if (status_wr && bus.din[ST_FRAME_ERR])      frame_err_reg <= 1'b0;
    end
  end

  // TX FSM; TxD is registered from the current state, so it lags state by one cycle
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tx_state_reg <= TX_IDLE;
      tx_cnt_reg   <= '0;
      tx_bit_reg   <= '0;
      tx_shift_reg <= '0;
      txd_reg      <= 1'b1;
    end else begin
      txd_reg <= (tx_state_reg == TX_START) ? 1'b0 :
                 (tx_state_reg == TX_DATA)  ? tx_shift_reg[0] : 1'b1;
      case (tx_state_reg)
        TX_IDLE: begin
          if (tx_pop) begin
            tx_state_reg <= TX_START;
            tx_cnt_reg   <= div_reg;
            tx_shift_reg <= tx_head;
          end
        end
        TX_START: begin
          if (tx_cnt_reg == '0) begin
            tx_state_reg <= TX_DATA;
            tx_cnt_reg   <= div_reg;
            tx_bit_reg   <= '0;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 1'b1;
          end
        end
        TX_DATA: begin
          if (tx_cnt_reg == '0) begin
            tx_cnt_reg   <= div_reg;
            tx_shift_reg <= {1'b0, tx_shift_reg[7:1]};
            tx_bit_reg   <= tx_bit_reg + 1'b1;
            if (tx_bit_reg == 3'd7) tx_state_reg <= TX_STOP;
          end else begin
            tx_cnt_reg <= tx_cnt_reg - 1'b1;
          end
        end
        default: begin
          if (tx_cnt_reg == '0) tx_state_reg <= TX_IDLE;
          else                  tx_cnt_reg   <= tx_cnt_reg - 1'b1;
        end
      endcase
    end
  end

  // Two-flop synchroniser for the asynchronous serial input (idles high)
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync1_reg <= 1'b1;
      sync2_reg <= 1'b1;
    end else begin
      sync1_reg <= rx_src;
      sync2_reg <= sync1_reg;
    end
  end

  // RX FSM: confirm start at half bit, then sample every full bit at mid-bit
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rx_state_reg <= RX_IDLE;
      rx_cnt_reg   <= '0;
      rx_bit_reg   <= '0;
      rx_shift_reg <= '0;
    end else begin
      case (rx_state_reg)
        RX_IDLE: begin
          if (ctrl_reg[CTRL_RX_EN] && !sync2_reg) begin
            rx_state_reg <= RX_START;
            rx_cnt_reg   <= {1'b0, div_reg[15:1]};
          end
        end
        RX_START: begin
          if (rx_cnt_reg == '0) begin
            if (!sync2_reg) begin
              rx_state_reg <= RX_DATA;
              rx_cnt_reg   <= div_reg;
              rx_bit_reg   <= '0;
            end else begin
              rx_state_reg <= RX_IDLE;
            end
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 1'b1;
          end
        end
        RX_DATA: begin
          if (rx_cnt_reg == '0) begin
            rx_cnt_reg   <= div_reg;
            rx_shift_reg <= {sync2_reg, rx_shift_reg[7:1]};
            rx_bit_reg   <= rx_bit_reg + 1'b1;
            if (rx_bit_reg == 3'd7) rx_state_reg <= RX_STOP;
          end else begin
            rx_cnt_reg <= rx_cnt_reg - 1'b1;
          end
        end
        default: begin
          if (rx_cnt_reg == '0) rx_state_reg <= RX_IDLE;
          else                  rx_cnt_reg   <= rx_cnt_reg - 1'b1;
        end
      endcase
    end
  end

  // Registered level interrupt
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) irq_reg <= 1'b0;
    else irq_reg <= (ctrl_reg[CTRL_IRQ_RX_EN] & (rx_avail | overrun_reg | frame_err_reg)) |
                    (ctrl_reg[CTRL_IRQ_TX_EN] & tx_empty & ~tx_busy);
  end

  // STATUS word assembly
  always_comb begin
    status                = '0;
    status[ST_TX_FULL]    = tx_full;
    status[ST_TX_EMPTY]   = tx_empty;
    status[ST_RX_AVAIL]   = rx_avail;
    status[ST_RX_FULL]    = rx_full;
    status[ST_RX_OVERRUN] = overrun_reg;
    status[ST_FRAME_ERR]  = frame_err_reg;
    status[ST_TX_BUSY]    = tx_busy;
  end

  // Combinational read mux; empty RX FIFO reads as zero
  always_comb begin
    rdata = '0;
    case (bus.addr)
      REG_DATA:   if (rx_avail) rdata[7:0] = rx_head;
      REG_STATUS: rdata[6:0]  = status;
      REG_CTRL:   rdata[4:0]  = ctrl_reg;
      REG_DIV:    rdata[15:0] = div_reg;
      default:    rdata = '0;
    endcase
  end

  assign bus.dout = rdata;

endmodule

// File: tb/tb_uart_fifo_periph.sv
// Directed self-checking bench for uart_fifo_periph.
module tb_uart_fifo_periph;
  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int BIT   = 4;   // DIV=3 -> 4 clk per bit

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic RxD = 1'b1;
  logic TxD;
  logic irq;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  uart_fifo_periph_if #(.WIDTH(WIDTH)) bus ();

  uart_fifo_periph #(.WIDTH(WIDTH), .FIFO_DEPTH(DEPTH), .DIV_RESET(16'd433)) dut (
    .clk(clk), .resetn(resetn), .bus(bus.slave), .RxD(RxD), .TxD(TxD), .irq(irq)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s = 0x%0h", tag, got);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.wen = 1'b1; bus.ren = 1'b0; bus.addr = a; bus.din = d;
    @(negedge clk);
    bus.cs = 1'b0; bus.wen = 1'b0;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.cs = 1'b1; bus.ren = 1'b1; bus.wen = 1'b0; bus.addr = a;
    #1 d = bus.dout;
    @(negedge clk);
    bus.cs = 1'b0; bus.ren = 1'b0;
  endtask

  // Drive one 8N1 frame on RxD at BIT clocks per bit
  task automatic send_rx(input logic [7:0] b, input logic stop);
    @(negedge clk);
    RxD = 1'b0;
    repeat (BIT) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      repeat (BIT) @(negedge clk);
    end
    RxD = stop;
    repeat (BIT) @(negedge clk);
    RxD = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Wait (bounded) for a start bit on TxD and decode the frame at mid-bit
  task automatic tx_capture(output logic [7:0] b, output logic stop, output logic ok);
    int n;
    ok = 1'b0; n = 0; b = '0; stop = 1'b0;
    while (!ok && n < 300) begin
      @(negedge clk);
      if (TxD == 1'b0) ok = 1'b1;
      n++;
    end
    if (ok) begin
      repeat (2) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (BIT) @(negedge clk);
        b[i] = TxD;
      end
      repeat (BIT) @(negedge clk);
      stop = TxD;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] d;
    logic [7:0]  b;
    logic        stp;
    logic        ok;
    logic        all_high;
    int          low_len;
    int          frames;
    int          n;

    bus.cs = 1'b0; bus.wen = 1'b0; bus.ren = 1'b0; bus.addr = 4'd1; bus.din = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    check("reset_txd", {31'd0, TxD}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    check("reset_status_comb", bus.dout, 32'h02);
    resetn = 1'b1;
    bus_rd(4'd1, d); check("status_after_reset", d, 32'h02);
    bus_rd(4'd3, d); check("div_reset", d, 32'd433);
    bus_rd(4'd2, d); check("ctrl_reset", d, 32'd0);

    // Single TX frame 0x55
    bus_wr(4'd3, 32'd3);
    bus_wr(4'd2, 32'h1);
    bus_wr(4'd0, 32'h55);
    bus.addr = 4'd1;
    ok = 1'b0; n = 0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (TxD == 1'b0) ok = 1'b1;
      n++;
    end
    check("tx_start_seen", {31'd0, ok}, 32'd1);
    low_len = 1;
    while (TxD == 1'b0 && low_len < 20) begin
      @(negedge clk);
      if (TxD == 1'b0) low_len++;
    end
    check("tx_start_len", low_len, BIT);
    #1 check("tx_busy_mid", {31'd0, bus.dout[6]}, 32'd1);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      b[i] = TxD;
      repeat (BIT) @(negedge clk);
    end
    stp = TxD;
    check("tx_byte_55", {24'd0, b}, 32'h55);
    check("tx_stop_55", {31'd0, stp}, 32'd1);
    repeat (10) @(negedge clk);
    bus_rd(4'd1, d); check("tx_idle_status", d, 32'h02);

    // Single RX frame 0xA3
    bus_wr(4'd2, 32'h2);
    send_rx(8'hA3, 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(4'd1, d); check("rx_avail_status", d, 32'h06);
    bus_rd(4'd0, d); check("rx_data_a3", d, 32'hA3);
    bus_rd(4'd1, d); check("rx_drained_status", d, 32'h02);
    bus_rd(4'd0, d); check("rx_empty_read", d, 32'h0);

    // TX FIFO overfill with tx disabled, then drain
    bus_wr(4'd2, 32'h0);
    for (int i = 0; i < DEPTH + 1; i++) bus_wr(4'd0, 32'h10 + i);
    bus_rd(4'd1, d); check("tx_full_status", d, 32'h01);
    bus_wr(4'd2, 32'h1);
    frames = 0; ok = 1'b1;
    while (ok && frames < DEPTH + 2) begin
      tx_capture(b, stp, ok);
      if (ok) begin
        check($sformatf("tx_fifo_byte%0d", frames), {23'd0, stp, b}, {23'd1, 8'(8'h10 + frames)});
        frames++;
      end
    end
    check("tx_frame_count", frames, DEPTH);
    bus_rd(4'd1, d); check("tx_drained_status", d, 32'h02);

    // RX overrun: 9 frames, no reads
    bus_wr(4'd2, 32'h2);
    for (int i = 0; i < DEPTH + 1; i++) send_rx(8'h21 + 8'(i), 1'b1);
    repeat (4) @(negedge clk);
    bus_rd(4'd1, d); check("rx_overrun_status", d, 32'h1E);
    bus_wr(4'd1, 32'h10);
    bus_rd(4'd1, d); check("rx_overrun_w1c", d, 32'h0E);
    for (int i = 0; i < DEPTH; i++) begin
      bus_rd(4'd0, d);
      check($sformatf("rx_fifo_byte%0d", i), d, 32'h21 + i);
    end
    bus_rd(4'd1, d); check("rx_fifo_drained", d, 32'h02);

    // Glitch rejection
    @(negedge clk); RxD = 1'b0;
    @(negedge clk); RxD = 1'b1;
    repeat (60) @(negedge clk);
    bus_rd(4'd1, d); check("glitch_no_byte", d, 32'h02);

    // Framing error and interrupts
    send_rx(8'h5A, 1'b0);
    repeat (4) @(negedge clk);
    bus_rd(4'd1, d); check("frame_err_status", d, 32'h22);
    bus_wr(4'd2, 32'h6);
    @(negedge clk); @(negedge clk);
    check("irq_frame_err", {31'd0, irq}, 32'd1);
    bus_wr(4'd1, 32'h20);
    bus_rd(4'd1, d); check("frame_err_w1c", d, 32'h02);
    @(negedge clk); @(negedge clk);
    check("irq_cleared", {31'd0, irq}, 32'd0);
    bus_wr(4'd2, 32'h8);
    @(negedge clk); @(negedge clk);
    check("irq_tx_empty", {31'd0, irq}, 32'd1);
    bus_wr(4'd2, 32'h0);
    @(negedge clk); @(negedge clk);
    check("irq_off", {31'd0, irq}, 32'd0);

    // Loopback bit
    bus_wr(4'd2, 32'h13);
`ifdef UART_LOOPBACK_EN
    bus_rd(4'd2, d); check("ctrl_loopback_rb", d, 32'h13);
    bus_wr(4'd0, 32'h3C);
    all_high = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (TxD !== 1'b1) all_high = 1'b0;
    end
    check("loopback_txd_high", {31'd0, all_high}, 32'd1);
    bus_rd(4'd1, d); check("loopback_status", d, 32'h06);
    bus_rd(4'd0, d); check("loopback_data", d, 32'h3C);
`else
    bus_rd(4'd2, d); check("ctrl_no_loopback_rb", d, 32'h03);
    bus_wr(4'd0, 32'h3C);
    all_high = 1'b1;
    tx_capture(b, stp, ok);
    check("ext_tx_seen", {31'd0, ok}, 32'd1);
    check("ext_tx_byte", {23'd0, stp, b}, 32'h13C);
    repeat (10) @(negedge clk);
    bus_rd(4'd1, d); check("ext_tx_no_rx", {31'd0, all_high} & {31'd0, d[2]}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/uart_fifo_periph.md
Name: uart_fifo_periph

Overview:
- Second-generation memory-mapped UART peripheral on the CPU bus.
- Full-duplex 8N1 transmitter and receiver with a runtime-programmable baud divisor.
- Parametrised TX and RX FIFOs, a status/control register pair and an interrupt output.
- Bus-side read/write semantics are unchanged from the first-generation UART; receive path, buffering and status reporting are new.

Parameters:
- WIDTH, 32: bus data width; must be ≥ 16.
- FIFO_DEPTH, 8: entries per FIFO; power of two, 2..64.
- DIV_RESET, 16'd433: baud divisor after reset; bit time = DIV+1 clk cycles.

Ports:
- clk  in  1  system clock, rising edge.
- resetn  in  1  asynchronous active-low reset.
- cs  in  1  peripheral select.
- wen  in  1  write strobe, qualified by cs.
- ren  in  1  read strobe, qualified by cs; pops RX FIFO on DATA read.
- addr  in  4  register index.
- din  in  WIDTH  write data.
- dout  out  WIDTH  read data, combinational from addr.
- RxD  in  1  serial input, asynchronous.
- TxD  out  1  serial output, idle high.
- irq  out  1  level interrupt, registered.

Behaviour:
- Register map (unlisted addresses read 0, writes ignored):
  - 0 DATA: write pushes din[7:0] to TX FIFO; read returns RX head in [7:0].
  - 1 STATUS (read-only except W1C bits):
    - b0 tx_full, b1 tx_empty, b2 rx_avail, b3 rx_full, b6 tx_busy.
    - b4 rx_overrun, b5 frame_err: sticky, cleared by writing 1.
  - 2 CTRL: b0 tx_en, b1 rx_en, b2 irq_rx_en, b3 irq_tx_en, b4 loopback (see optional feature).
  - 3 DIV: [15:0] baud divisor.
- Access timing:
  - Writes take effect at the clk edge where cs & wen.
  - DATA pop occurs at the edge where cs & ren & addr==0 & rx_avail.
  - Read of an empty RX FIFO returns 0; no pop.
- Reset (resetn low, asynchronous): TxD=1, irq=0, FIFOs empty, CTRL=0, DIV=DIV_RESET, sticky bits 0, both FSMs in IDLE.
  - dout therefore reads STATUS=0x02 (tx_empty) after reset.
- Baud timing: per-direction counter reloads DIV each bit. A DIV write mid-frame takes effect at the next bit boundary.
- TX FSM: IDLE → START → DATA (8 bits, LSB first) → STOP → IDLE.
  - Leaves IDLE when tx_en & TX FIFO not empty; pops on the START entry cycle.
  - First TxD low appears 1 cycle after the pop edge.
  - Clearing tx_en mid-frame finishes the current frame, then no further pops.
  - tx_busy = state≠IDLE.
- RX path:
  - RxD passes a 2-flop synchroniser.
  - RX FSM: IDLE → START → DATA → STOP.
  - START is confirmed by sampling low at half bit (DIV/2, truncated); otherwise return to IDLE (glitch reject).
  - Data bits are sampled at each mid-bit.
  - STOP sampled low: byte discarded, frame_err set.
  - Valid byte with RX FIFO full: byte discarded, rx_overrun set.
  - rx_en=0 holds the FSM in IDLE; a frame in progress completes.
- FIFO rules:
  - Push to a full TX FIFO is dropped silently.
  - Simultaneous push and pop are both honoured, including at full and at empty+push+pop; occupancy is unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - Full/empty are derived from a (log2(FIFO_DEPTH)+1)-bit count.
- irq is registered, asserting 1 cycle after its condition holds:
  - (irq_rx_en & (rx_avail | rx_overrun | frame_err)) | (irq_tx_en & tx_empty & !tx_busy).

Optional Feature:
- Macro: UART_LOOPBACK_EN.
  - Defined: CTRL b4 is writable. When 1, the RX synchroniser input is the internal TxD and the external TxD is held 1.
  - Undefined: CTRL b4 reads 0, writes are ignored, and no mux is present.

Decomposition:
- Package uart_fifo_pkg:
  - Register index constants REG_DATA/REG_STATUS/REG_CTRL/REG_DIV.
  - STATUS and CTRL bit positions.
  - TX/RX FSM state encodings (2-bit).
- Sub-module uart_sync_fifo (params DW=8, DEPTH), instantiated twice: push/pop/full/empty/count, data-out from head with no read latency.

Test Plan:
- Reset, then read addr 1 → 0x02; TxD=1, irq=0; read addr 3 → 433.
- DIV=3, CTRL=0x1, write 0x55 → TxD pattern 0,1,0,1,0,1,0,1,0,1 with 4 clk per bit; tx_busy clears after STOP.
- DIV=3, CTRL=0x2, drive RxD frame 0xA3 → rx_avail=1; DATA read returns 0xA3, then rx_avail=0.
- Push FIFO_DEPTH+1 bytes with tx_en=0 → tx_full=1, 9th byte lost; enable → exactly 8 frames.
- Receive 9 frames without reading → rx_overrun=1, first 8 bytes intact; write STATUS 0x10 → bit clears.
- RxD 1-clk low glitch → no byte. Frame with STOP=0 → frame_err=1, irq=1 with CTRL=0x6. With UART_LOOPBACK_EN and CTRL=0x13, write 0x3C → RX reads 0x3C and external TxD stays 1.
